alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 173 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin arbitration,
// one operation in flight, registered result held until its owner consumes it.

module alu_arbiter_alu #(
  parameter int N = 32
) (
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] result_o,
  output logic [3:0]   flags_o
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_PSA = 3'd6;

  logic [N:0]   ext;
  logic [N-1:0] res;
  logic         carry;
  logic         ovf;

  // SUB reports C as an unsigned borrow (a < b); logic ops never set C or V.
  always_comb begin
    ext   = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_i)
      OP_ADD: begin
        ext   = {1'b0, a_i} + {1'b0, b_i};
        res   = ext[N-1:0];
        carry = ext[N];
        ovf   = (a_i[N-1] == b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      OP_SUB: begin
        ext   = {1'b0, a_i} - {1'b0, b_i};
        res   = ext[N-1:0];
        carry = ext[N];
        ovf   = (a_i[N-1] != b_i[N-1]) && (res[N-1] != a_i[N-1]);
      end
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_NOR:  res = ~(a_i | b_i);
      OP_PSA:  res = a_i;
      default: res = b_i;
    endcase
  end

  assign result_o = res;
  assign flags_o  = {res[N-1], (res == '0), carry, ovf};
endmodule

module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         req0_valid_i,
  output logic         req0_ready_o,
  input  logic [N-1:0] req0_a_i,
  input  logic [N-1:0] req0_b_i,
  input  logic [2:0]   req0_op_i,
  input  logic         req1_valid_i,
  output logic         req1_ready_o,
  input  logic [N-1:0] req1_a_i,
  input  logic [N-1:0] req1_b_i,
  input  logic [2:0]   req1_op_i,
  output logic         rsp0_valid_o,
  input  logic         rsp0_ready_i,
  output logic         rsp1_valid_o,
  input  logic         rsp1_ready_i,
  output logic [N-1:0] rsp_result_o,
  output logic [3:0]   rsp_flags_o,
  output logic         busy_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         id_q, id_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic [N-1:0] res_q, res_d;
  logic [3:0]   flags_q, flags_d;

  logic         any_req;
  logic         grant_id;
  logic         rsp_take;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;

  alu_arbiter_alu #(.N(N)) u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .result_o(alu_result),
    .flags_o (alu_flags)
  );

  // Under contention the requester that did not win last time goes next.
  assign any_req  = req0_valid_i | req1_valid_i;
  assign grant_id = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
  assign rsp_take = id_q ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d    = grant_id;
          last_d  = grant_id;
          a_d     = grant_id ? req1_a_i  : req0_a_i;
          b_d     = grant_id ? req1_b_i  : req0_b_i;
          op_d    = grant_id ? req1_op_i : req0_op_i;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flags_d = alu_flags;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  // Ready is gated by reset too, so a held-high valid cannot show ready while in reset.
  assign req0_ready_o = rst_n_i && (state_q == IDLE) && any_req && !grant_id;
  assign req1_ready_o = rst_n_i && (state_q == IDLE) && any_req &&  grant_id;
  assign rsp0_valid_o = (state_q == RESP) && !id_q;
  assign rsp1_valid_o = (state_q == RESP) &&  id_q;
  assign rsp_result_o = (state_q == RESP) ? res_q   : '0;
  assign rsp_flags_o  = (state_q == RESP) ? flags_q : '0;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all watched by a transaction-level model every cycle.

module tb_alu_arbiter;
  localparam int N = 32;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.N(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_op_i(req0_op),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_op_i(req1_op),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Reference ALU from the arithmetic definitions: flags {N,Z,C,V}.
  function automatic void alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    longint unsigned ua, ub;
    longint sa, sb, sr;
    logic c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; sr = 0;
    case (op)
      3'd0: begin r = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb;
                  v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      3'd1: begin r = 32'(ua - ub); c = ua < ub; sr = sa - sb;
                  v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = a;
      default: r = b;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Transaction model: one operation in flight, visible two cycles after its handshake cycle.
  bit          m_busy;
  bit          m_last;
  int          m_age;
  int          m_id;
  logic [31:0] m_res;
  logic [3:0]  m_flags;

  initial begin
    bit v0, v1, has, take;
    int w;
    logic er0, er1, ev0, ev1, eb;
    logic [31:0] eres;
    logic [3:0]  efl;
    m_busy = 0; m_last = 1; m_age = 0; m_id = 0; m_res = 0; m_flags = 0;
    forever begin
      @(negedge clk);
      v0 = req0_valid; v1 = req1_valid; has = v0 || v1;
      w  = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
      if (!rst_n) begin
        er0 = 0; er1 = 0; ev0 = 0; ev1 = 0; eb = 0; eres = 0; efl = 0;
      end else begin
        er0 = !m_busy && has && (w == 0);
        er1 = !m_busy && has && (w == 1);
        ev0 = m_busy && (m_age >= 2) && (m_id == 0);
        ev1 = m_busy && (m_age >= 2) && (m_id == 1);
        eb  = m_busy;
        eres = (ev0 || ev1) ? m_res : 32'd0;
        efl  = (ev0 || ev1) ? m_flags : 4'd0;
      end
      chk("mon_req0_ready", req0_ready, er0);
      chk("mon_req1_ready", req1_ready, er1);
      chk("mon_rsp0_valid", rsp0_valid, ev0);
      chk("mon_rsp1_valid", rsp1_valid, ev1);
      chk("mon_result", rsp_result, eres);
      chk("mon_flags", rsp_flags, efl);
      chk("mon_busy", busy, eb);
      if (!rst_n) begin
        m_busy = 0; m_last = 1; m_age = 0;
      end else if (!m_busy && has) begin
        m_busy = 1; m_age = 1; m_id = w; m_last = (w == 1);
        if (w == 0) alu_ref(req0_op, req0_a, req0_b, m_res, m_flags);
        else        alu_ref(req1_op, req1_a, req1_b, m_res, m_flags);
      end else if (m_busy) begin
        take = (m_id == 0) ? rsp0_ready : rsp1_ready;
        if (m_age >= 2 && take) m_busy = 0;
        else if (m_age < 2) m_age++;
      end
    end
  end

  // Called at posedge+1; returns after the handshake edge, at posedge+1.
  task automatic issue(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int waited);
    bit got;
    waited = 0;
    if (k == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1; end
    else        begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = (k == 0) ? req0_ready : req1_ready;
      waited++;
      @(posedge clk); #1;
      if (got) break;
    end
    if (k == 0) req0_valid = 0; else req1_valid = 0;
    if (waited >= 20) chk("issue_timeout", 0, 1);
  endtask

  // Waits for the response of requester k, captures it, then consumes it.
  task automatic collect(input int k, output logic [31:0] r, output logic [3:0] f,
                         output int lat, output logic other);
    bit seen;
    seen = 0; lat = 0; r = 0; f = 0; other = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if ((k == 0) ? rsp0_valid : rsp1_valid) begin
        r = rsp_result; f = rsp_flags; other = (k == 0) ? rsp1_valid : rsp0_valid;
        seen = 1;
        break;
      end
    end
    if (!seen) chk("collect_timeout", 0, 1);
    @(posedge clk); #1;
    if (k == 0) rsp0_ready = 1; else rsp1_ready = 1;
    @(posedge clk); #1;
    if (k == 0) rsp0_ready = 0; else rsp1_ready = 0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] corner [4];
    corner[0] = 32'h0; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF; corner[3] = 32'h8000_0000;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    int waited, lat;
    logic [31:0] r;
    logic [3:0] f;
    logic other;
    bit hs0, hs1;
    rst_n = 0;
    req0_valid = 1; req0_a = 0; req0_b = 0; req0_op = OP_ADD;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = OP_ADD;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0_gated", req0_ready, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1; req0_valid = 0;

    // Single ADD right after reset release: first edge handshake, 2-cycle latency.
    issue(0, OP_ADD, 32'h5, 32'h3, waited);
    chk("add_first_edge", waited, 1);
    collect(0, r, f, lat, other);
    chk("add_latency", lat, 2);
    chk("add_result", r, 32'h8);
    chk("add_flags", f, 4'b0000);

    // Fresh reset, then three contentions: 0, 1, 0.
    rst_n = 0; @(posedge clk); #1; rst_n = 1;
    for (int t = 0; t < 3; t++) begin
      req0_a = t; req0_b = 10; req0_op = OP_ADD; req0_valid = 1;
      req1_a = t; req1_b = 20; req1_op = OP_ADD; req1_valid = 1;
      @(negedge clk);
      chk("arb_grant", {req1_ready, req0_ready}, (t == 1) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      collect((t == 1) ? 1 : 0, r, f, lat, other);
      chk("arb_result", r, (t == 1) ? 32'(t + 20) : 32'(t + 10));
    end

    issue(1, OP_ADD, 32'hFFFF_FFFF, 32'h1, waited);
    collect(1, r, f, lat, other);
    chk("wrap_result", r, 32'h0);
    chk("wrap_flags", f, 4'b0110);
    chk("wrap_rsp0_quiet", other, 0);

    issue(1, OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, waited);
    collect(1, r, f, lat, other);
    chk("and_result", r, 32'h0);
    chk("and_flags", f, 4'b0100);

    issue(0, OP_SUB, 32'h3, 32'h5, waited);
    collect(0, r, f, lat, other);
    chk("sub_result", r, 32'hFFFF_FFFE);
    chk("sub_flags", f, 4'b1010);

    // Stalled response: req1 waits, and req1's own rsp_ready is ignored.
    issue(0, OP_ADD, 32'h7FFF_FFFF, 32'h1, waited);
    req1_a = 32'h1; req1_b = 32'h2; req1_op = OP_OR; req1_valid = 1; rsp1_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp0_valid, 1);
      chk("stall_result", rsp_result, 32'h8000_0000);
      chk("stall_flags", rsp_flags, 4'b1001);
      chk("stall_busy", busy, 1);
      chk("stall_req1_blocked", req1_ready, 0);
      @(posedge clk); #1;
    end
    rsp0_ready = 1; rsp1_ready = 0;
    @(negedge clk);
    chk("consume_cycle_no_ready", req1_ready, 0);
    @(posedge clk); #1;
    rsp0_ready = 0;
    @(negedge clk);
    chk("req1_after_consume", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    collect(1, r, f, lat, other);
    chk("req1_or_result", r, 32'h3);

    // Asynchronous reset while a response is pending.
    issue(0, OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, waited);
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp0_valid) break;
      waited++;
    end
    chk("pre_reset_resp", rsp0_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("async_rst_result", rsp_result, 32'h0);
    chk("async_rst_flags", rsp_flags, 4'h0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {rsp1_valid, rsp0_valid, busy}, 3'b000);
    end
    @(posedge clk); #1;
    issue(0, OP_OR, 32'h1, 32'h2, waited);
    collect(0, r, f, lat, other);
    chk("post_reset_result", r, 32'h3);
    chk("post_reset_flags", f, 4'b0000);

    // Randomized traffic; the monitor checks every cycle.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 3'($urandom_range(0, 7)); req0_a = rnd_opnd(); req0_b = rnd_opnd();
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 3'($urandom_range(0, 7)); req1_a = rnd_opnd(); req1_b = rnd_opnd();
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
